// File: rtl/tone_seq_player.sv
// Queued note sequencer and square-wave tone generator for the buzzer: notes arrive
// through a small FIFO and each plays for a number of beats followed by a silent gap.
module tone_seq_player #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BEAT_HZ    = 4,
    parameter int unsigned GAP_CLKS   = 2_500_000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DUR_W      = 4,
    parameter int unsigned HP_W       = 24
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        note_valid,
    output logic                        note_ready,
    input  logic [5+DUR_W-1:0]          note_data,
    input  logic                        stop,
    output logic                        speaker,
    output logic                        busy,
    output logic                        beat_pulse,
    output logic [1:0]                  cur_oct,
    output logic [2:0]                  cur_deg,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned BEAT_CLKS = CLK_HZ / BEAT_HZ;
    localparam int unsigned NOTE_W    = 5 + DUR_W;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned CNT_W     = $clog2(((2 ** DUR_W) - 1) * BEAT_CLKS) + 1;
    localparam int unsigned BC_W      = $clog2(BEAT_CLKS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_TONE = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    generate
        if (GAP_CLKS >= BEAT_CLKS) begin : g_bad_gap
            $error("tone_seq_player: GAP_CLKS must be smaller than CLK_HZ/BEAT_HZ");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("tone_seq_player: FIFO_DEPTH must be a power of two and at least 2");
        end
        if ((64'(CLK_HZ / 32'd524) << 1) >= (64'd1 << HP_W)) begin : g_bad_hp_w
            $error("tone_seq_player: HP_W too narrow for the lowest-octave half-period");
        end
    endgenerate

    // Half-period in clocks for one octave/degree; degree 0 is a rest and yields 0.
    function automatic logic [HP_W-1:0] hp_lookup(input logic [1:0] oct, input logic [2:0] deg);
        logic [HP_W+1:0] mid;
        logic [HP_W+1:0] hp;
        case (deg)
            3'd1:    mid = (HP_W+2)'(CLK_HZ / 32'd524);
            3'd2:    mid = (HP_W+2)'(CLK_HZ / 32'd588);
            3'd3:    mid = (HP_W+2)'(CLK_HZ / 32'd660);
            3'd4:    mid = (HP_W+2)'(CLK_HZ / 32'd698);
            3'd5:    mid = (HP_W+2)'(CLK_HZ / 32'd784);
            3'd6:    mid = (HP_W+2)'(CLK_HZ / 32'd880);
            3'd7:    mid = (HP_W+2)'(CLK_HZ / 32'd988);
            default: mid = {(HP_W+2){1'b0}};
        endcase
        case (oct)
            2'd0:    hp = mid << 1'b1;
            2'd1:    hp = mid;
            2'd2:    hp = mid >> 1'b1;
            2'd3:    hp = mid >> 2'd2;
            default: hp = mid;
        endcase
        return hp[HP_W-1:0];
    endfunction

    logic [NOTE_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r, count_next_s;
    logic              ready_r;

    logic [1:0]        state_r, state_next_s;
    logic [NOTE_W-1:0] note_r;
    logic [HP_W-1:0]   hp_last_r, hp_cnt_r, hp_last_s;
    logic [CNT_W-1:0]  note_cnt_r, tone_last_r, note_last_r;
    logic [CNT_W-1:0]  total_s, tone_last_s, note_last_s;
    logic [BC_W-1:0]   beat_cnt_r, beat_cnt_next_s;
    logic              speaker_r, beat_pulse_r, busy_r, beat_pulse_next_s;
    logic [1:0]        cur_oct_r;
    logic [2:0]        cur_deg_r;

    logic              push_s, pop_s, fifo_empty_s, gap_done_s, tone_done_s;
    logic [1:0]        oct_s;
    logic [2:0]        deg_s;
    logic [DUR_W-1:0]  dur_s;

    // Handshake, next state, occupancy, beat tracking and per-note arithmetic
    always_comb begin
        oct_s        = note_r[NOTE_W-1 -: 2];
        deg_s        = note_r[DUR_W+2:DUR_W];
        dur_s        = note_r[DUR_W-1:0];
        hp_last_s    = hp_lookup(oct_s, deg_s) - HP_W'(1'b1);
        total_s      = CNT_W'(dur_s) * CNT_W'(BEAT_CLKS);
        tone_last_s  = total_s - CNT_W'(GAP_CLKS + 32'd1);
        note_last_s  = total_s - CNT_W'(32'd1);
        push_s       = note_valid && ready_r && !stop;
        fifo_empty_s = (count_r == {CW{1'b0}});
        gap_done_s   = (state_r == ST_GAP) && (note_cnt_r == note_last_r);
        tone_done_s  = (state_r == ST_TONE) && (note_cnt_r == tone_last_r);
        pop_s        = !stop && !fifo_empty_s && ((state_r == ST_IDLE) || gap_done_s);
        state_next_s = ST_IDLE;
        if (stop) begin
            state_next_s = ST_IDLE;
            count_next_s = {CW{1'b0}};
        end else begin
            count_next_s = count_r + CW'(push_s) - CW'(pop_s);
            case (state_r)
                ST_IDLE: state_next_s = pop_s ? ST_LOAD : ST_IDLE;
                ST_LOAD: state_next_s = (dur_s == {DUR_W{1'b0}}) ? ST_IDLE : ST_TONE;
                ST_TONE: state_next_s = tone_done_s ? ST_GAP : ST_TONE;
                ST_GAP: begin
                    if (gap_done_s) begin
                        state_next_s = pop_s ? ST_LOAD : ST_IDLE;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
        case (state_r)
            ST_TONE, ST_GAP: begin
                if (beat_cnt_r == BC_W'(BEAT_CLKS - 32'd1)) begin
                    beat_cnt_next_s = {BC_W{1'b0}};
                end else begin
                    beat_cnt_next_s = beat_cnt_r + BC_W'(1'b1);
                end
            end
            default: beat_cnt_next_s = {BC_W{1'b0}};
        endcase
        beat_pulse_next_s = ((state_next_s == ST_TONE) || (state_next_s == ST_GAP)) &&
                            (beat_cnt_next_s == BC_W'(BEAT_CLKS - 32'd1));
    end

    // Queue pointers, occupancy and flow-control flag; stop flushes like reset
    always_ff @(posedge sys_clk) begin
        if (rst || stop) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            count_r <= count_next_s;
            ready_r <= (count_next_s != CW'(FIFO_DEPTH));
        end
    end

    // Queue storage; occupancy alone decides which entries are meaningful
    always_ff @(posedge sys_clk) begin
        if (push_s) mem_r[wr_ptr_r] <= note_data;
    end

    // Note sequencer: load, tone generation, gap and status outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            note_r       <= {NOTE_W{1'b0}};
            hp_last_r    <= {HP_W{1'b0}};
            hp_cnt_r     <= {HP_W{1'b0}};
            note_cnt_r   <= {CNT_W{1'b0}};
            tone_last_r  <= {CNT_W{1'b0}};
            note_last_r  <= {CNT_W{1'b0}};
            beat_cnt_r   <= {BC_W{1'b0}};
            speaker_r    <= 1'b0;
            beat_pulse_r <= 1'b0;
            busy_r       <= 1'b0;
            cur_oct_r    <= 2'd0;
            cur_deg_r    <= 3'd0;
        end else begin
            state_r      <= state_next_s;
            beat_cnt_r   <= beat_cnt_next_s;
            beat_pulse_r <= beat_pulse_next_s;
            busy_r       <= (state_next_s != ST_IDLE) || (count_next_s != {CW{1'b0}});
            if (pop_s) note_r <= mem_r[rd_ptr_r];
            if (stop) begin
                speaker_r  <= 1'b0;
                cur_oct_r  <= 2'd0;
                cur_deg_r  <= 3'd0;
                hp_cnt_r   <= {HP_W{1'b0}};
                note_cnt_r <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        hp_last_r   <= hp_last_s;
                        tone_last_r <= tone_last_s;
                        note_last_r <= note_last_s;
                        hp_cnt_r    <= {HP_W{1'b0}};
                        note_cnt_r  <= {CNT_W{1'b0}};
                        speaker_r   <= 1'b0;
                        if ((dur_s != {DUR_W{1'b0}}) && (deg_s != 3'd0)) begin
                            cur_oct_r <= oct_s;
                            cur_deg_r <= deg_s;
                        end
                    end
                    ST_TONE: begin
                        note_cnt_r <= note_cnt_r + CNT_W'(1'b1);
                        if (hp_cnt_r == hp_last_r) begin
                            hp_cnt_r  <= {HP_W{1'b0}};
                            speaker_r <= (deg_s != 3'd0) ? ~speaker_r : 1'b0;
                        end else begin
                            hp_cnt_r <= hp_cnt_r + HP_W'(1'b1);
                        end
                        // The gap starts silent even if a toggle lands on the last tone cycle
                        if (tone_done_s) begin
                            speaker_r <= 1'b0;
                            cur_oct_r <= 2'd0;
                            cur_deg_r <= 3'd0;
                        end
                    end
                    ST_GAP: begin
                        note_cnt_r <= note_cnt_r + CNT_W'(1'b1);
                        speaker_r  <= 1'b0;
                    end
                    default: begin
                        speaker_r <= 1'b0;
                        cur_oct_r <= 2'd0;
                        cur_deg_r <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign note_ready = ready_r;
    assign speaker    = speaker_r;
    assign busy       = busy_r;
    assign beat_pulse = beat_pulse_r;
    assign cur_oct    = cur_oct_r;
    assign cur_deg    = cur_deg_r;
    assign fifo_count = count_r;

endmodule

// File: doc/tone_seq_player.md
Name: tone_seq_player

Overview:
- Parametrised successor of the fixed-table buzzer song player: queued note sequencer and square-wave tone generator for the on-board buzzer.
- Upstream logic (score ROM reader, keypad, UART) pushes note words through a valid/ready FIFO.
- The block plays each note for a programmed number of beats, with an articulation gap between notes, then drives `speaker`.
- Exposes current octave/degree for the seven-segment display path.

Parameters:
- CLK_HZ, 100_000_000, `sys_clk` frequency; all timing constants derive from it at elaboration.
- BEAT_HZ, 4, beat rate; BEAT_CLKS = CLK_HZ/BEAT_HZ.
- GAP_CLKS, 2_500_000, silent cycles at the end of every note; must be < BEAT_CLKS (elaboration error otherwise).
- FIFO_DEPTH, 8, note queue depth; power of two, ≥2.
- DUR_W, 4, width of the duration field in beats.
- HP_W, 24, width of the half-period counter; must hold the low-octave degree-1 half-period.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- note_valid  in  1  note word offered.
- note_ready  out  1  FIFO not full.
- note_data  in  5+DUR_W  {oct[1:0], deg[2:0], dur[DUR_W-1:0]}.
- stop  in  1  flush queue, silence immediately.
- speaker  out  1  square-wave buzzer drive.
- busy  out  1  FSM not IDLE or FIFO not empty.
- beat_pulse  out  1  one-cycle pulse at each beat boundary of the playing note.
- cur_oct  out  2  octave of the sounding note, 0 when silent.
- cur_deg  out  3  degree of the sounding note, 0 when silent.
- fifo_count  out  clog2(FIFO_DEPTH)+1  queued words.

Behaviour:
- Reset (`rst`=1 at a `sys_clk` edge):
  - All outputs 0 except note_ready=1.
  - FIFO emptied, FSM to IDLE, all counters cleared.
  - Reset mid-note silences `speaker` on the next cycle.
- Pitch table:
  - Middle-octave frequencies are 262, 294, 330, 349, 392, 440, 494 Hz for deg 1..7.
  - HPMID[d] = floor(CLK_HZ/(2*F[d])).
  - Half-period HP by octave: oct 0 = HPMID<<1; oct 1 = HPMID; oct 2 = HPMID>>1; oct 3 = HPMID>>2.
  - deg 0 = rest: `speaker` stays 0 and cur_oct/cur_deg stay 0 for the full duration.
- FIFO:
  - Write when note_valid && note_ready. note_ready = !full.
  - Simultaneous push and pop while full is not allowed: ready is already low.
  - Simultaneous push and pop otherwise leaves the count unchanged.
- FSM states: IDLE, LOAD, TONE, GAP.
  - IDLE: if FIFO not empty, pop into the note register and go to LOAD.
  - LOAD: one cycle. Compute HP and total = dur*BEAT_CLKS.
    - dur==0: drop the note and return to IDLE.
    - Otherwise clear the counters and go to TONE.
  - TONE:
    - Half-period counter counts 0..HP-1; `speaker` toggles when it reaches HP-1, then the counter wraps.
    - `speaker` starts at 0, so the first rising edge is HP cycles after TONE entry.
    - The note counter increments every cycle. At count == total-GAP_CLKS-1, go to GAP.
  - GAP: `speaker` forced 0, cur_oct/cur_deg forced 0.
    - At note count == total-1: go to LOAD if the FIFO is non-empty (the pop happens in that cycle), else IDLE.
    - Back-to-back notes therefore have exactly one LOAD cycle, no IDLE cycle.
- Sequence latency: a word accepted at cycle t into an empty idle block gives IDLE pop at t+1, LOAD at t+2, TONE at t+3.
- beat_pulse: asserted on the last cycle of each BEAT_CLKS window of the note counter, including the final beat, which occurs in GAP.
- stop:
  - Takes effect on the same edge and beats any push that cycle; the pushed word is discarded.
  - Flushes the FIFO and goes to IDLE. `speaker`, cur_oct and cur_deg are 0 from the next cycle.
- Width rules:
  - The note counter is clog2((2^DUR_W-1)*BEAT_CLKS)+1 bits.
  - All comparisons are unsigned; no wrap is possible within a note.

Test Plan:
- Test parameters for all scenarios: CLK_HZ=1_000_000, BEAT_HZ=1000 (BEAT_CLKS=1000), GAP_CLKS=100, FIFO_DEPTH=4, DUR_W=4.
- Push {1,6,2} (mid A, 2 beats):
  - HP=1136, total=2000.
  - `speaker` rises 1136 cycles after TONE entry and stays high; TONE lasts 1900 cycles, then 100 cycles low.
  - beat_pulse at note cycles 999 and 1999; cur_deg=6 during TONE.
- Push {2,1,1} then {0,1,1}:
  - HP=954 then HP=3816.
  - Exactly one LOAD cycle separates the two notes; busy drops 1 cycle after the second GAP ends.
- Push {1,0,3} (rest):
  - `speaker`=0 and cur_deg=0 for 3000 cycles; 3 beat_pulses occur.
- Hold note_valid for 6 words with the player stalled in a long note:
  - note_ready falls after the 4th FIFO write (first word already popped); fifo_count=4.
  - No word is lost or duplicated; playback order equals push order.
- Push {1,3,0}:
  - The word is dropped after LOAD; returns to IDLE; `speaker` never toggles.
- Assert stop mid-TONE with 3 words queued, then repeat with `rst` instead:
  - Next cycle: `speaker`=0, fifo_count=0, busy=0, note_ready=1.
